unary_block_count: RTL and testbench

UNARY_BLOCK_COUNT -- requirements
Module: unary_block_count

---
 rtl/unary_pkg.sv | 20 ++
 rtl/unary_popcount.sv | 18 +
 rtl/unary_block_count.sv | 119 +++++++++++
 tb/tb_unary_block_count.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/unary_pkg.sv
// Shared definitions for the unary-to-binary block counter and its companion generator.
// Holds the two-state FSM encoding and the window-geometry helper functions.
package unary_pkg;

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Number of beats that make up one window of 2**bwidth unary bits.
   function automatic int beats_per_window(input int uwidth, input int bwidth);
      return (1 << bwidth) / uwidth;
   endfunction

   // Beat counter width; a single-beat window still keeps a one-bit counter.
   function automatic int beat_cnt_width(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/unary_popcount.sv
// Combinational population count of one unary beat.
// Output is wide enough to hold the all-ones case (W).
module unary_popcount #(
   parameter int W = 2,
   localparam int CW = $clog2(W) + 1
) (
   input  logic [W-1:0]  bits,
   output logic [CW-1:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < W; i++) begin
         count = count + CW'(bits[i]);
      end
   end

endmodule

// File: rtl/unary_block_count.sv
// Counts the ones in each 2**BWIDTH-bit unary window and hands the total out on a ready/valid port.
// Define UNARY_CHECK_EN to build the sticky thermometer-code violation detector (code_err).
module unary_block_count
   import unary_pkg::*;
#(
   parameter int UWIDTH = 2,
   parameter int BWIDTH = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [UWIDTH-1:0] u_in,
   input  logic              u_in_valid,
   output logic              u_in_ready,
   input  logic              clear,
   output logic [BWIDTH:0]   bin_out,
   output logic              bin_out_valid,
   input  logic              bin_out_ready,
   output logic              code_err
);

   localparam int BEATS = beats_per_window(UWIDTH, BWIDTH);
   localparam int CNTW  = beat_cnt_width(BEATS);
   localparam int PCW   = $clog2(UWIDTH) + 1;
   localparam int AW    = BWIDTH + 1;
   localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(BEATS - 1);

   state_t          state;
   logic [AW-1:0]   acc;
   logic [CNTW-1:0] beat_cnt;
   logic [PCW-1:0]  beat_ones;
   logic [AW-1:0]   sum;
   logic            take;
   logic            last;

   unary_popcount #(
      .W(UWIDTH)
   ) u_popcount (
      .bits  (u_in),
      .count (beat_ones)
   );

   assign u_in_ready = (state == ACC);
   // A clear swallows any beat offered in the same cycle, including a window-completing one.
   assign take       = u_in_valid && u_in_ready && !clear;
   assign sum        = acc + AW'(beat_ones);
   assign last       = (beat_cnt == LAST_BEAT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ACC;
         acc           <= '0;
         beat_cnt      <= '0;
         bin_out       <= '0;
         bin_out_valid <= 1'b0;
      end else begin
         if (clear) begin
            acc      <= '0;
            beat_cnt <= '0;
         end else if (take) begin
            if (last) begin
               acc           <= '0;
               beat_cnt      <= '0;
               bin_out       <= sum;
               bin_out_valid <= 1'b1;
               state         <= HOLD;
            end else begin
               acc      <= sum;
               beat_cnt <= beat_cnt + CNTW'(1);
            end
         end

         // The held result is released only by the consumer, never by clear.
         if (state == HOLD && bin_out_ready) begin
            bin_out_valid <= 1'b0;
            state         <= ACC;
         end
      end
   end

`ifdef UNARY_CHECK_EN
   logic seen_zero;
   logic seen_zero_next;
   logic beat_viol;
   logic err_q;

   // Walk the beat in bit-time order, carrying whether a 0 has already appeared in this window.
   always_comb begin
      seen_zero_next = seen_zero;
      beat_viol      = 1'b0;
      for (int i = 0; i < UWIDTH; i++) begin
         if (u_in[i] && seen_zero_next) begin
            beat_viol = 1'b1;
         end
         if (!u_in[i]) begin
            seen_zero_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seen_zero <= 1'b0;
         err_q     <= 1'b0;
      end else if (clear) begin
         seen_zero <= 1'b0;
      end else if (take) begin
         seen_zero <= last ? 1'b0 : seen_zero_next;
         if (beat_viol) begin
            err_q <= 1'b1;
         end
      end
   end

   assign code_err = err_q;
`else
   assign code_err = 1'b0;
`endif

endmodule

// File: tb/tb_unary_block_count.sv
// Directed bench for unary_block_count at UWIDTH=2, BWIDTH=4 (eight beats per window).
// Table-driven full windows followed by hand-written backpressure, clear, gap and reset sequences.
module tb_unary_block_count;

   logic       clk;
   logic       reset_n;
   logic [1:0] u_in;
   logic       u_in_valid;
   logic       u_in_ready;
   logic       clear;
   logic [4:0] bin_out;
   logic       bin_out_valid;
   logic       bin_out_ready;
   logic       code_err;

   int tests;
   int failed;

   typedef struct {
      string      name;
      logic [15:0] beats;
      int         exp_bin;
      logic       exp_err;
   } vec_t;

   vec_t vecs[7];

   unary_block_count #(
      .UWIDTH(2),
      .BWIDTH(4)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .u_in          (u_in),
      .u_in_valid    (u_in_valid),
      .u_in_ready    (u_in_ready),
      .clear         (clear),
      .bin_out       (bin_out),
      .bin_out_valid (bin_out_valid),
      .bin_out_ready (bin_out_ready),
      .code_err      (code_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic sendBeat(input logic [1:0] b);
      @(negedge clk);
      u_in       = b;
      u_in_valid = 1'b1;
   endtask

   // Drives one full window (beat 0 in bits [1:0]) and returns at the negedge after the last transfer.
   task automatic applyStimulus(input logic [15:0] beats);
      for (int i = 0; i < 8; i++) begin
         sendBeat(beats[2*i +: 2]);
      end
      @(negedge clk);
      u_in_valid = 1'b0;
      u_in       = 2'b00;
   endtask

   task automatic doReset();
      @(negedge clk);
      reset_n       = 1'b0;
      clear         = 1'b0;
      u_in_valid    = 1'b0;
      u_in          = 2'b00;
      bin_out_ready = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   function automatic logic errExpect(input logic e);
`ifdef UNARY_CHECK_EN
      return e;
`else
      return 1'b0;
`endif
   endfunction

   initial begin
      tests         = 0;
      failed        = 0;
      reset_n       = 1'b0;
      clear         = 1'b0;
      u_in          = 2'b00;
      u_in_valid    = 1'b0;
      bin_out_ready = 1'b1;

      vecs[0] = '{name: "all11",      beats: 16'hFFFF, exp_bin: 16, exp_err: 1'b0};
      vecs[1] = '{name: "therm7",     beats: 16'h007F, exp_bin: 7,  exp_err: 1'b0};
      vecs[2] = '{name: "all00",      beats: 16'h0000, exp_bin: 0,  exp_err: 1'b0};
      vecs[3] = '{name: "viol01_10",  beats: 16'h0009, exp_bin: 2,  exp_err: 1'b1};
      vecs[4] = '{name: "all10",      beats: 16'hAAAA, exp_bin: 8,  exp_err: 1'b1};
      vecs[5] = '{name: "therm15",    beats: 16'h7FFF, exp_bin: 15, exp_err: 1'b0};
      vecs[6] = '{name: "late_one",   beats: 16'h4000, exp_bin: 1,  exp_err: 1'b1};

      #3;
      checkOutput("reset bin_out", bin_out, 0);
      checkOutput("reset bin_out_valid", bin_out_valid, 0);
      checkOutput("reset code_err", code_err, 0);
      checkOutput("reset u_in_ready", u_in_ready, 1);
      @(negedge clk);
      reset_n = 1'b1;

      for (int v = 0; v < 7; v++) begin
         doReset();
         applyStimulus(vecs[v].beats);
         checkOutput({vecs[v].name, " valid"}, bin_out_valid, 1);
         checkOutput({vecs[v].name, " bin_out"}, bin_out, vecs[v].exp_bin);
         checkOutput({vecs[v].name, " code_err"}, code_err, errExpect(vecs[v].exp_err));
         @(negedge clk);
         checkOutput({vecs[v].name, " valid one cycle"}, bin_out_valid, 0);
         checkOutput({vecs[v].name, " ready again"}, u_in_ready, 1);
      end

      // Violation stays flagged across a clean window and clears only on reset.
      doReset();
      applyStimulus(16'h0009);
      @(negedge clk);
      applyStimulus(16'hFFFF);
      checkOutput("sticky bin_out", bin_out, 16);
      checkOutput("sticky code_err", code_err, errExpect(1'b1));
      doReset();
      checkOutput("sticky cleared by reset", code_err, 0);

      // Backpressure: result held five cycles while beats are offered and refused.
      doReset();
      bin_out_ready = 1'b0;
      applyStimulus(16'h007F);
      for (int c = 0; c < 5; c++) begin
         checkOutput($sformatf("hold%0d u_in_ready", c), u_in_ready, 0);
         checkOutput($sformatf("hold%0d bin_out", c), bin_out, 7);
         checkOutput($sformatf("hold%0d valid", c), bin_out_valid, 1);
         u_in       = 2'b11;
         u_in_valid = 1'b1;
         @(negedge clk);
      end
      bin_out_ready = 1'b1;
      u_in_valid    = 1'b0;
      @(negedge clk);
      checkOutput("hold release valid", bin_out_valid, 0);
      checkOutput("hold release ready", u_in_ready, 1);
      applyStimulus(16'h0000);
      checkOutput("after hold bin_out", bin_out, 0);
      checkOutput("after hold valid", bin_out_valid, 1);

      // Clear mid-window with a same-cycle beat.
      doReset();
      for (int i = 0; i < 3; i++) sendBeat(2'b11);
      @(negedge clk);
      u_in       = 2'b11;
      u_in_valid = 1'b1;
      clear      = 1'b1;
      @(negedge clk);
      clear      = 1'b0;
      u_in_valid = 1'b0;
      applyStimulus(16'hAAAA);
      checkOutput("clear mid bin_out", bin_out, 8);
      checkOutput("clear mid valid", bin_out_valid, 1);

      // Clear beats a window-completing beat.
      doReset();
      for (int i = 0; i < 7; i++) sendBeat(2'b11);
      @(negedge clk);
      u_in       = 2'b11;
      u_in_valid = 1'b1;
      clear      = 1'b1;
      @(negedge clk);
      clear      = 1'b0;
      u_in_valid = 1'b0;
      checkOutput("clear prio valid", bin_out_valid, 0);
      checkOutput("clear prio ready", u_in_ready, 1);
      applyStimulus(16'h5555);
      checkOutput("clear prio bin_out", bin_out, 8);

      // Idle cycles between beats hold state.
      doReset();
      for (int i = 0; i < 8; i++) begin
         sendBeat(2'b11);
         @(negedge clk);
         u_in_valid = 1'b0;
      end
      checkOutput("gaps bin_out", bin_out, 16);
      checkOutput("gaps valid", bin_out_valid, 1);

      // Asynchronous reset while a result is pending.
      doReset();
      bin_out_ready = 1'b0;
      applyStimulus(16'hFFFF);
      checkOutput("pre-reset bin_out", bin_out, 16);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("async hold bin_out", bin_out, 0);
      checkOutput("async hold valid", bin_out_valid, 0);
      checkOutput("async hold ready", u_in_ready, 1);
      @(negedge clk);
      reset_n       = 1'b1;
      bin_out_ready = 1'b1;

      // Asynchronous reset mid-window discards the partial count.
      for (int i = 0; i < 4; i++) sendBeat(2'b11);
      @(negedge clk);
      u_in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      checkOutput("async mid bin_out", bin_out, 0);
      checkOutput("async mid valid", bin_out_valid, 0);
      checkOutput("async mid code_err", code_err, 0);
      checkOutput("async mid ready", u_in_ready, 1);
      @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(16'h0000);
      checkOutput("post reset bin_out", bin_out, 0);
      checkOutput("post reset valid", bin_out_valid, 1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
